program_loader: RTL

- Sequences the write port of the 16-bit instruction memory. Accepts a byte stream over a valid/ready handshake, packs byte pairs into instruction words, and issues one write per word at consecutive addresses from a programmed base.
- Holds the CPU in reset until a load completes, then releases it.
- Sits between the host/boot interface and the instruction memory's writeInstruction / Inputinstruction / MemoryAddress inputs.

---
 rtl/loader_pkg.sv | 15 +
 rtl/program_loader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader and the instruction memory it feeds.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_FIRST,
        GET_SECOND,
        WRITE,
        DONE
    } loader_state_t;

    localparam int DEFAULT_DEPTH     = 101;
    localparam bit DEFAULT_LOW_FIRST = 1'b1;

endpackage

// File: rtl/program_loader.sv
// Packs a byte stream into 16-bit instruction words, writes them to consecutive
// instruction-memory addresses and keeps the CPU in reset until a load completes.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter bit LOW_FIRST = DEFAULT_LOW_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [15:0]       instr_data,
    output logic              instr_we,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int EXT_W = ADDR_W + 1;

    loader_state_t     state;
    logic [ADDR_W-1:0] cur;
    logic [15:0]       rem;
    logic [7:0]        b0;
    logic              ready_q;
    logic              we_q;
    logic [EXT_W-1:0]  end_addr;
    logic              start_ok;

    // End address is formed one bit wider so a huge base cannot wrap into range.
    assign end_addr = EXT_W'(base_addr) + EXT_W'(word_count);
    assign start_ok = (word_count != 16'd0) && (end_addr <= EXT_W'(DEPTH));

    // Abort and reset must kill a handshake or write already presented this cycle.
    assign in_ready   = ready_q && !abort && !rst;
    assign instr_we   = we_q && !abort && !rst;
    assign instr_addr = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            rem        <= '0;
            b0         <= '0;
            instr_data <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            we_q  <= 1'b0;
            if (abort && state != IDLE) begin
                state   <= IDLE;
                ready_q <= 1'b0;
                busy    <= 1'b0;
                error   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (start_ok) begin
                                cur      <= base_addr;
                                rem      <= word_count;
                                cpu_hold <= 1'b1;
                                busy     <= 1'b1;
                                ready_q  <= 1'b1;
                                state    <= GET_FIRST;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    GET_FIRST: begin
                        if (in_valid) begin
                            b0    <= in_byte;
                            state <= GET_SECOND;
                        end
                    end
                    GET_SECOND: begin
                        if (in_valid) begin
                            instr_data <= LOW_FIRST ? {in_byte, b0} : {b0, in_byte};
                            ready_q    <= 1'b0;
                            we_q       <= 1'b1;
                            state      <= WRITE;
                        end
                    end
                    WRITE: begin
                        cur <= cur + 1'b1;
                        rem <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            cpu_hold <= 1'b0;
                            state    <= DONE;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= GET_FIRST;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
